car_sensor_conditioner: RTL

Conditions the four raw road-side vehicle sensors of the four-way intersection and produces the single car-present request `X` consumed by the highway/country traffic controller. Each sensor is debounced, watched for a stuck-high fault, and masked if faulty. The surviving sensors are OR-ed and stretched by a hold window, so short gaps between cars do not end a country-road green early. The block also keeps a saturating arrival count for monitoring.

---
 rtl/car_sensor_conditioner.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/car_sensor_conditioner.sv
// Conditions four raw vehicle sensors into one car-present request X:
// debounce, stuck-high fault masking, hold stretch, arrival counting.
// Optional input synchronizer: define SENSOR_SYNC_EN.
module car_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int HOLD_CYCLES     = 4,
    parameter int STUCK_CYCLES    = 60
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] sens,
    output logic       X,
    output logic [3:0] stable,
    output logic [3:0] fault,
    output logic [7:0] arrivals
);

    localparam logic [3:0] DEB_LAST  = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES);
    localparam logic [7:0] STUCK_LIM = 8'(STUCK_CYCLES);

    logic [3:0] samp;

`ifdef SENSOR_SYNC_EN
    logic [3:0] sync1_q, sync1_d;
    logic [3:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = sens;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign samp = sync2_q;
`else
    assign samp = sens;
`endif

    logic [3:0] deb_cnt_q [4];
    logic [3:0] deb_cnt_d [4];
    logic [3:0] stable_q, stable_d;
    logic [7:0] stuck_cnt_q [4];
    logic [7:0] stuck_cnt_d [4];
    logic [3:0] fault_q, fault_d;
    logic [3:0] hold_q, hold_d;
    logic [7:0] arrivals_q, arrivals_d;
    logic [3:0] active;
    logic [3:0] rise;
    logic [2:0] rise_cnt;
    logic [8:0] arr_sum;

    // Debounce: a run of DEBOUNCE_CYCLES contrary samples flips the state.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            stable_d[i]  = stable_q[i];
            if (samp[i] == stable_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                stable_d[i]  = ~stable_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 4'd1;
            end
        end
    end

    // Stuck counter saturates at its limit so the fault flag stays set.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            stuck_cnt_d[i] = stuck_cnt_q[i];
            fault_d[i]     = fault_q[i];
            if (!stable_q[i]) begin
                stuck_cnt_d[i] = '0;
            end else if (stuck_cnt_q[i] != STUCK_LIM) begin
                stuck_cnt_d[i] = stuck_cnt_q[i] + 8'd1;
            end
            if (stuck_cnt_d[i] == STUCK_LIM) begin
                fault_d[i] = 1'b1;
            end
        end
    end

    assign active = stable_q & ~fault_q;

    always_comb begin
        hold_d = hold_q;
        if (|active) begin
            hold_d = HOLD_LOAD;
        end else if (hold_q != 4'd0) begin
            hold_d = hold_q - 4'd1;
        end
    end

    // Arrivals: count debounced rises on sensors not yet faulted.
    always_comb begin
        rise     = stable_d & ~stable_q & ~fault_q;
        rise_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            rise_cnt = rise_cnt + 3'(rise[i]);
        end
        arr_sum    = {1'b0, arrivals_q} + {6'd0, rise_cnt};
        arrivals_d = arr_sum[8] ? 8'hFF : arr_sum[7:0];
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i]   <= '0;
                stuck_cnt_q[i] <= '0;
            end
            stable_q   <= '0;
            fault_q    <= '0;
            hold_q     <= '0;
            arrivals_q <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                deb_cnt_q[i]   <= deb_cnt_d[i];
                stuck_cnt_q[i] <= stuck_cnt_d[i];
            end
            stable_q   <= stable_d;
            fault_q    <= fault_d;
            hold_q     <= hold_d;
            arrivals_q <= arrivals_d;
        end
    end

    assign X        = (|active) | (hold_q != 4'd0);
    assign stable   = stable_q;
    assign fault    = fault_q;
    assign arrivals = arrivals_q;

endmodule
